// File: rtl/product_acc_pkg.sv
// -----------------------------------------------------------------------------
// product_acc_pkg
//   Shared types and constants for the product accumulator slice.
//   PROD_W      : width of the signed multiplier product stream.
//   ACC_W_MAX   : widest accumulator the slice supports (LEN up to 1024).
//   acc_state_t : output-side state of the accumulator (ACC / HOLD).
//   sext_to_acc : sign-extends a product to ACC_W_MAX; callers narrow it to
//                 their own ACC_W with a size cast.
// -----------------------------------------------------------------------------
package product_acc_pkg;

    localparam int PROD_W       = 64;
    localparam int LEN_MAX_LOG2 = 10;
    localparam int ACC_W_MAX    = PROD_W + LEN_MAX_LOG2;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_t;

    typedef logic signed [ACC_W_MAX-1:0] acc_max_t;

    localparam logic signed [PROD_W-1:0] PROD_MAX = {1'b0, {(PROD_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] PROD_MIN = {1'b1, {(PROD_W-1){1'b0}}};

    function automatic acc_max_t sext_to_acc(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W_MAX-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/product_accumulator_delay.sv
// -----------------------------------------------------------------------------
// valid_delay_line
//   Single-bit shift register that delays the operand-issue strobe so it lines
//   up with the product leaving the (stall-free) multiplier pipeline.
//   Ports:
//     clk   : rising-edge clock
//     rst   : asynchronous active-high reset, empties the line
//     clear : synchronous flush, empties the line
//     d     : strobe in
//     q     : strobe out, exactly DEPTH cycles after d
// -----------------------------------------------------------------------------
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else if (clear) begin
                    sr <= '0;
                end else begin
                    sr <= d;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else if (clear) begin
                    sr <= '0;
                end else begin
                    sr <= {sr[DEPTH-2:0], d};
                end
            end
        end
    endgenerate

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Sums LEN consecutive valid products from a pipelined 32x32 multiplier into
//   one signed frame result and presents it on a valid/ready port. The
//   multiplier has no valid of its own, so the issue strobe is carried through
//   a MUL_LAT-deep delay line (pv) to mark which prod values are real.
//   The accumulator and the output register are separate, so the next frame
//   keeps accumulating while the previous one waits for the consumer.
//
//   Ports:
//     clk       : rising-edge clock
//     rst       : asynchronous active-high reset
//     issue     : operands driven into the multiplier this cycle
//     prod      : signed multiplier product (PROD_W bits)
//     clear     : synchronous flush of delay line, accumulator and flags
//     out_valid : sum holds a completed frame
//     out_ready : consumer accepts sum
//     sum       : signed frame sum (ACC_W bits)
//     count     : products accumulated in the current frame
//     sat_hit   : presented sum was clamped
//     drop_err  : sticky, a completed frame was lost to backpressure
//
//   Build option:
//     PRODUCT_ACC_SAT_EN : clamp completed frames to the signed 64-bit range
//                          and report it on sat_hit. Undefined: full-width
//                          sum, sat_hit stays 0.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   ACC   | output register empty; next completed frame loads it
//   HOLD  | output register holds a frame (out_valid=1), waiting for out_ready
// -----------------------------------------------------------------------------
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int LEN     = 4,
    parameter int ACC_W   = PROD_W + $clog2(LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    input  logic signed [PROD_W-1:0] prod,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  sum,
    output logic [$clog2(LEN)-1:0]   count,
    output logic                     sat_hit,
    output logic                     drop_err
);

    localparam int               CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    logic pv;

    valid_delay_line #(
        .DEPTH (MUL_LAT)
    ) u_align (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .d     (issue),
        .q     (pv)
    );

    acc_state_t              state, state_n;
    logic signed [ACC_W-1:0] acc, acc_n;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] frame;
    logic signed [ACC_W-1:0] frame_out;
    logic signed [ACC_W-1:0] sum_n;
    logic [CNT_W-1:0]        count_n;
    logic                    complete;
    logic                    frame_sat;
    logic                    sat_n;
    logic                    drop_n;

    assign prod_ext = ACC_W'(sext_to_acc(prod));
    assign frame    = acc + prod_ext;
    assign complete = pv && (count == LAST);

`ifdef PRODUCT_ACC_SAT_EN
    // The frame fits in PROD_W bits only if every bit from the PROD_W sign
    // position upward agrees.
    logic [ACC_W-PROD_W:0] frame_hi;
    logic                  frame_ovf;

    assign frame_hi  = frame[ACC_W-1:PROD_W-1];
    assign frame_ovf = !((&frame_hi) || !(|frame_hi));
    assign frame_out = frame_ovf
                     ? (frame[ACC_W-1] ? ACC_W'(sext_to_acc(PROD_MIN))
                                       : ACC_W'(sext_to_acc(PROD_MAX)))
                     : frame;
    assign frame_sat = frame_ovf;
`else
    assign frame_out = frame;
    assign frame_sat = 1'b0;
`endif

    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        sum_n   = sum;
        sat_n   = sat_hit;
        drop_n  = drop_err;

        if (clear) begin
            state_n = ACC;
            acc_n   = '0;
            count_n = '0;
            sat_n   = 1'b0;
            drop_n  = 1'b0;
        end else begin
            if (complete) begin
                acc_n   = '0;
                count_n = '0;
            end else if (pv) begin
                acc_n   = acc + prod_ext;
                count_n = count + 1'b1;
            end

            case (state)
                ACC: begin
                    if (complete) begin
                        sum_n   = frame_out;
                        sat_n   = frame_sat;
                        state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (complete) begin
                            // back-to-back handoff, no bubble
                            sum_n = frame_out;
                            sat_n = frame_sat;
                        end else begin
                            state_n = ACC;
                        end
                    end else if (complete) begin
                        // output register still owned by the consumer
                        drop_n = 1'b1;
                    end
                end
                default: state_n = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACC;
            acc      <= '0;
            count    <= '0;
            sum      <= '0;
            sat_hit  <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            count    <= count_n;
            sum      <= sum_n;
            sat_hit  <= sat_n;
            drop_err <= drop_n;
        end
    end

    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int MUL_LAT = 4;
    localparam int LEN     = 4;
    localparam int ACC_W   = 64 + $clog2(LEN);

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef struct {
        int                 due;
        logic signed [63:0] val;
    } mul_t;

    localparam longint MAXL = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam longint MINL = 64'sh8000_0000_0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               issue;
    logic signed [63:0] prod;
    logic               clear;
    logic               out_valid;
    logic               out_ready;
    acc_t               sum;
    logic [1:0]         count;
    logic               sat_hit;
    logic               drop_err;

    product_accumulator #(
        .MUL_LAT (MUL_LAT),
        .LEN     (LEN),
        .ACC_W   (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .prod      (prod),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .count     (count),
        .sat_hit   (sat_hit),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic acc_t sx(input longint v);
        return acc_t'(v);
    endfunction

    function automatic logic signed [63:0] mul(input int a, input int b);
        return longint'(a) * longint'(b);
    endfunction

    // ---------------- behavioural reference model ----------------
    // Multiplier: a product issued in cycle c is on prod during cycle c+MUL_LAT.
    mul_t mq[$];
    bit   tb_pv = 1'b0;
    int   cyc   = 0;

    logic signed [63:0] frame_q[$];
    bit   m_valid = 1'b0;
    acc_t m_sum   = '0;
    bit   m_sat   = 1'b0;
    bit   m_drop  = 1'b0;
    acc_t m_f;
    bit   m_done;
    bit   m_fsat;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q.delete();
            m_valid = 1'b0;
            m_sum   = '0;
            m_sat   = 1'b0;
            m_drop  = 1'b0;
        end else if (clear) begin
            frame_q.delete();
            m_valid = 1'b0;
            m_sat   = 1'b0;
            m_drop  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (tb_pv) begin
                frame_q.push_back(prod);
                if (frame_q.size() == LEN) begin
                    m_f = '0;
                    foreach (frame_q[i]) m_f = m_f + acc_t'(frame_q[i]);
                    frame_q.delete();
                    m_done = 1'b1;
                end
            end
            if (m_done) begin
                m_fsat = 1'b0;
`ifdef PRODUCT_ACC_SAT_EN
                if (m_f > sx(MAXL)) begin
                    m_f = sx(MAXL);
                    m_fsat = 1'b1;
                end else if (m_f < sx(MINL)) begin
                    m_f = sx(MINL);
                    m_fsat = 1'b1;
                end
`endif
                if (!m_valid || out_ready) begin
                    m_sum   = m_f;
                    m_sat   = m_fsat;
                    m_valid = 1'b1;
                end else begin
                    m_drop = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid", 128'(out_valid), 128'(m_valid));
        check("sum",       128'(sum),       128'(m_sum));
        check("count",     128'(count),     128'(frame_q.size()));
        check("sat_hit",   128'(sat_hit),   128'(m_sat));
        check("drop_err",  128'(drop_err),  128'(m_drop));
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit iss, input logic signed [63:0] pval, input bit clr, input bit rdy);
        issue     = iss;
        clear     = clr;
        out_ready = rdy;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            prod  = mq[0].val;
            tb_pv = 1'b1;
            void'(mq.pop_front());
        end else begin
            prod  = {$urandom, $urandom} | 64'h1;
            tb_pv = 1'b0;
        end
        if (clr) mq.delete();
        if (iss && !clr) mq.push_back(mul_t'{cyc + MUL_LAT, pval});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, rdy);
    endtask

    // Four back-to-back products of v; out_ready=rdy_last only in the cycle
    // the fourth product is sampled.
    task automatic frame4(input logic signed [63:0] v, input bit rdy_last);
        for (int i = 0; i < 4; i++) step(1'b1, v, 1'b0, 1'b0);
        idle(3, 1'b0);
        check("frame4_count_before_last", 128'(count), 128'(3));
        step(1'b0, '0, 1'b0, rdy_last);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        acc_t e_nosat;
        rst = 1'b1; issue = 1'b0; clear = 1'b0; out_ready = 1'b0; prod = '0;
        @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_sum",       128'(sum),       128'(sx(0)));
        check("rst_count",     128'(count),     128'(0));
        check("rst_sat_hit",   128'(sat_hit),   128'(0));
        check("rst_drop_err",  128'(drop_err),  128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic frame: 6 * -7 four times
        frame4(mul(6, -7), 1'b0);
        check("basic_valid", 128'(out_valid), 128'(1));
        check("basic_sum",   128'(sum),       128'(sx(-168)));
        check("basic_count", 128'(count),     128'(0));

        // gapped issue
        idle(1, 1'b1);
        check("gap_drained", 128'(out_valid), 128'(0));
        step(1'b1, mul(5, 1), 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, mul(-3, 1), 1'b0, 1'b0);
        idle(1, 1'b0);
        step(1'b1, mul(10, 1), 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, mul(2, 1), 1'b0, 1'b0);
        idle(3, 1'b0);
        check("gap_not_yet_valid", 128'(out_valid), 128'(0));
        check("gap_count3",        128'(count),     128'(3));
        idle(1, 1'b0);
        check("gap_valid", 128'(out_valid), 128'(1));
        check("gap_sum",   128'(sum),       128'(sx(14)));

        // backpressure
        idle(1, 1'b1);
        frame4(mul(1, 1), 1'b0);
        check("bp_f1_sum", 128'(sum), 128'(sx(4)));
        frame4(mul(1, 2), 1'b0);
        check("bp_drop",      128'(drop_err),  128'(1));
        check("bp_sum_kept",  128'(sum),       128'(sx(4)));
        check("bp_valid",     128'(out_valid), 128'(1));
        frame4(mul(1, 3), 1'b1);
        check("bp_b2b_sum",   128'(sum),       128'(sx(12)));
        check("bp_b2b_valid", 128'(out_valid), 128'(1));

        // async reset mid-HOLD, between clock edges
        #2;
        rst = 1'b1;
        mq.delete();
        #1;
        check("arst_valid", 128'(out_valid), 128'(0));
        check("arst_sum",   128'(sum),       128'(sx(0)));
        check("arst_drop",  128'(drop_err),  128'(0));
        check("arst_count", 128'(count),     128'(0));
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;

        // clear mid-frame
        step(1'b1, mul(6, -7), 1'b0, 1'b0);
        step(1'b1, mul(6, -7), 1'b0, 1'b0);
        idle(4, 1'b0);
        check("clr_count2", 128'(count), 128'(2));
        step(1'b0, '0, 1'b1, 1'b0);
        check("clr_count0", 128'(count),     128'(0));
        check("clr_valid",  128'(out_valid), 128'(0));
        for (int i = 0; i < 5; i++) begin
            idle(1, 1'b0);
            check("clr_no_frame", 128'(out_valid), 128'(0));
        end
        frame4(mul(6, -7), 1'b0);
        check("clr_next_sum",   128'(sum),       128'(sx(-168)));
        check("clr_next_valid", 128'(out_valid), 128'(1));

        // large products
        idle(1, 1'b1);
        frame4(MAXL, 1'b0);
`ifdef PRODUCT_ACC_SAT_EN
        check("sat_sum", 128'(sum),     128'(sx(MAXL)));
        check("sat_hit", 128'(sat_hit), 128'(1));
`else
        e_nosat = {2'b01, 64'hFFFF_FFFF_FFFF_FFFC};
        check("nosat_sum", 128'(sum),     128'(e_nosat));
        check("nosat_hit", 128'(sat_hit), 128'(0));
`endif

        // randomized traffic
        idle(1, 1'b1);
        for (int i = 0; i < 2500; i++) begin
            logic signed [63:0] v;
            case ($urandom % 4)
                0:       v = MAXL;
                1:       v = MINL;
                default: v = {$urandom, $urandom};
            endcase
            step(1'($urandom % 2), v, ($urandom % 64) == 0, ($urandom % 4) != 0);
        end
        idle(MUL_LAT + 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Consumes the 64-bit signed product stream from the pipelined 32x32 multiplier and sums LEN consecutive valid products into one frame result.
- The multiplier has no valid or stall signal, so this block carries the operand-issue strobe through an internal MUL_LAT-deep delay line to line it up with the product.
- Each completed frame is presented on a valid/ready output port, with a one-frame skid (accumulator and output register are separate).

Parameters:
- MUL_LAT, 4: multiplier latency in cycles, from operands to prod; legal range 1..16.
- LEN, 4: products per frame; legal range 2..1024.
- ACC_W, 64+$clog2(LEN): accumulator and sum width; wide enough that a frame can never overflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- issue  in  1  high in the cycle operands a/b are driven into the multiplier.
- prod  in  64  signed product from the multiplier (its res).
- clear  in  1  synchronous flush.
- out_valid  out  1  sum holds a completed frame.
- out_ready  in  1  consumer accepts sum.
- sum  out  ACC_W  signed frame sum.
- count  out  $clog2(LEN)  products accumulated in the current frame.
- sat_hit  out  1  saturation occurred on the presented sum.
- drop_err  out  1  sticky: a frame was lost to backpressure.

Behaviour:
- Reset (async, rst=1): all of the following go to 0: delay line, acc, count, out_valid, sum, sat_hit, drop_err; state=ACC.
- Alignment: pv = issue delayed exactly MUL_LAT cycles. prod is sampled only when pv=1; prod is ignored when pv=0.
- Accumulate: on pv=1, acc <= acc + sign_extend(prod, ACC_W), count <= count+1.
- Frame completion: occurs when pv=1 and count==LEN-1.
  - frame = acc + sext(prod).
  - acc <= 0, count <= 0.
  - Output register is loaded as below.
- States:
  - ACC: out_valid=0. Frame completion loads sum <= frame, out_valid <= 1 next cycle, goes to HOLD.
  - HOLD: out_valid=1 and sum stays stable. Accumulation of the next frame continues.
    - out_ready=1, no completion in the same cycle: out_valid <= 0, go to ACC.
    - out_ready=1 and a completion in the same cycle: sum <= new frame, stay in HOLD. This is a back-to-back handoff with no bubble.
    - out_ready=0 and a completion in the same cycle: the new frame is discarded, drop_err <= 1 (sticky), acc/count still reset to 0, sum unchanged.
- Output latency: sum is valid on the cycle after the LEN-th product is sampled. From issue of the last operands, that is MUL_LAT+1 cycles.
- clear=1 (synchronous, highest priority after rst):
  - delay line, acc, count, out_valid, sat_hit and drop_err all go to 0; state=ACC.
  - sum keeps its value but is not valid.
  - A product sampled in the same cycle is discarded.
- Reset or clear mid-frame: the partial frame is lost; no output is produced.
- count wraps LEN-1 -> 0 only through a completion; it never exceeds LEN-1.

Optional Feature:
- Macro: PRODUCT_ACC_SAT_EN.
- Defined:
  - Completed frames are clamped to the signed 64-bit range [-2^63, 2^63-1], then sign-extended to ACC_W.
  - sat_hit=1 is loaded together with sum whenever clamping occurred, and 0 otherwise.
- Undefined: sum is the full ACC_W result and sat_hit is tied to 0.

Decomposition:
- Package product_acc_pkg:
  - PROD_W=64.
  - State enum {ACC, HOLD}.
  - Function sext_to_acc.
- Sub-module valid_delay_line: parameter DEPTH, ports clk, rst, clear, d, q. A shift register with async reset, used for the issue-to-pv alignment.

Test Plan:
- Basic frame: LEN=4, MUL_LAT=4. Issue a=6, b=-7 four consecutive cycles (prod=-42 each). Expect out_valid=1 at cycle issue0+MUL_LAT+4, sum=-168, count back to 0.
- Gapped issue: issue products 5, -3, 10, 2 with idle cycles between them. Expect sum=14 only after the 4th pv. Expect prod to be ignored while pv=0, even when its value is nonzero.
- Backpressure with back-to-back frames:
  - Hold out_ready=0. Complete frame1 (sum=4), then complete frame2. Expect drop_err=1 and sum still 4.
  - Then assert out_ready while frame3 completes. Expect sum to update to frame3's sum with out_valid held at 1.
- Clear mid-frame: after 2 products of -42, assert clear. Expect count=0, out_valid=0, no frame emitted. The next 4 products of -42 give sum=-168.
- Async reset mid-HOLD: assert rst between clock edges. Expect out_valid, sum and drop_err to go to 0 immediately, without waiting for a clock edge.
- PRODUCT_ACC_SAT_EN: four products of 0x7FFF_FFFF_FFFF_FFFF. Expect sum=2^63-1 and sat_hit=1. Without the macro, expect sum=4*(2^63-1) and sat_hit=0.
